sync_edge_event: RTL and testbench

//   Consumes the synchronized bus and its stable flag from the synchronizer stage.

---
 rtl/sync_edge_event_if.sv | 26 ++
 rtl/sync_edge_event.sv | 105 ++++++++++
 tb/tb_sync_edge_event.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sync_edge_event_if.sv
// Event stream bundle between the edge-event FIFO and its consumer.
//   event_tdata  : {timestamp, fall_mask, rise_mask} of the FIFO head
//   event_tvalid : head entry present
//   event_tready : consumer accepts the head this cycle
interface sync_edge_event_if #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned TS_WIDTH = 16
) ();
  localparam int unsigned DATA_W = TS_WIDTH + 2 * WIDTH;

  logic [DATA_W-1:0] event_tdata;
  logic              event_tvalid;
  logic              event_tready;

  modport master (
    output event_tdata,
    output event_tvalid,
    input  event_tready
  );

  modport slave (
    input  event_tdata,
    input  event_tvalid,
    output event_tready
  );
endinterface

// File: rtl/sync_edge_event.sv
// Per-bit edge detector on a synchronized bus; time-stamps each change and
// queues it as one event word in a small FIFO drained over a valid/ready stream.
//   clk, aresetn   : clock, synchronous active-low reset
//   din/din_stable : synchronized bus and its stable qualifier
//   evt            : event stream (master side), {ts, fall_mask, rise_mask}
//   fifo_level     : entries currently queued
//   overflow       : sticky drop flag, overflow_clear clears it
module sync_edge_event #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [WIDTH-1:0]                     din,
  input  logic                                 din_stable,
  sync_edge_event_if.master                    evt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 overflow,
  input  logic                                 overflow_clear
);
  localparam int unsigned DATA_W = TS_WIDTH + 2 * WIDTH;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);

  logic [TS_WIDTH-1:0] ts_q;
  logic                armed_q;
  logic [WIDTH-1:0]    ref_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic                tvalid_q;
  logic [DATA_W-1:0]   tdata_q;
  logic                overflow_q;

  logic                detect_c, full_c, pop_c, push_c, drop_c;
  logic [WIDTH-1:0]    rise_c, fall_c;
  logic [DATA_W-1:0]   word_c, head_n;
  logic [PTR_W-1:0]    wr_ptr_n, rd_ptr_n;
  logic [LVL_W-1:0]    level_n;

  // Detection and FIFO bookkeeping for the coming edge
  always_comb begin
    rise_c   = din & ~ref_q;
    fall_c   = ~din & ref_q;
    word_c   = {ts_q, fall_c, rise_c};
    detect_c = armed_q && din_stable && (din != ref_q);
    full_c   = (level_q == LVL_W'(FIFO_DEPTH));
    pop_c    = tvalid_q && evt.event_tready;
    push_c   = detect_c && (!full_c || pop_c);
    drop_c   = detect_c && full_c && !pop_c;

    wr_ptr_n = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_n = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_n = level_q;
    if (push_c && !pop_c)      level_n = level_q + LVL_W'(1);
    else if (pop_c && !push_c) level_n = level_q - LVL_W'(1);

    // Head after the edge: the word being written lands at the head only when
    // the queue is otherwise empty, so bypass it straight into the output flop.
    head_n = '0;
    if (level_n != '0) begin
      if (push_c && (rd_ptr_n == wr_ptr_q)) head_n = word_c;
      else                                  head_n = mem_q[rd_ptr_n];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      ts_q       <= '0;
      armed_q    <= 1'b0;
      ref_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
      // First stable sample only loads the reference; later ones track it
      if (din_stable) begin
        armed_q <= 1'b1;
        ref_q   <= din;
      end
      if (push_c) mem_q[wr_ptr_q] <= word_c;
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      level_q  <= level_n;
      tvalid_q <= (level_n != '0);
      tdata_q  <= head_n;
      // A drop on the same edge as a clear keeps the flag set
      if (drop_c)              overflow_q <= 1'b1;
      else if (overflow_clear) overflow_q <= 1'b0;
    end
  end

  assign evt.event_tdata  = tdata_q;
  assign evt.event_tvalid = tvalid_q;
  assign fifo_level       = level_q;
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_sync_edge_event.sv
module tb_sync_edge_event;
  localparam int unsigned WIDTH      = 4;
  localparam int unsigned TS_WIDTH   = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DATA_W     = TS_WIDTH + 2 * WIDTH;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [WIDTH-1:0] din;
  logic             din_stable;
  logic [2:0]       fifo_level;
  logic             overflow;
  logic             overflow_clear;

  sync_edge_event_if #(.WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH)) evt ();

  sync_edge_event #(.WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .din            (din),
    .din_stable     (din_stable),
    .evt            (evt.master),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT will stamp at the next rising edge
  logic [TS_WIDTH-1:0] ts_m;
  always @(posedge clk) begin
    if (!aresetn) ts_m <= '0;
    else          ts_m <= ts_m + 16'd1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Apply inputs at the falling edge, clock once, return at the next falling edge
  task automatic step(input logic [3:0] d, input logic st, input logic rdy, input logic clr);
    din = d; din_stable = st; evt.event_tready = rdy; overflow_clear = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [15:0] t, input logic [3:0] f, input logic [3:0] r);
    return {t, f, r};
  endfunction

  typedef struct {
    logic [3:0] din;
    logic       st;
    logic       rdy;
    logic       clr;
    logic       exp_v;
    logic [2:0] exp_lvl;
    logic [3:0] exp_fall;
    logic [3:0] exp_rise;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [11];
  logic [DATA_W-1:0] exp_q [$];
  logic [15:0] t;

  initial begin
    // ref starts at 0 (armed by the idle phase); rows with exp_v carry a freshly pushed head
    vecs[0]  = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'h0, 4'h5, 1'b0};
    vecs[3]  = '{4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0};
    vecs[4]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'h5, 4'hA, 1'b0};
    vecs[7]  = '{4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 4'h0, 4'h5, 1'b0};
    vecs[9]  = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 4'hF, 4'h0, 1'b0};
    vecs[10] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0};

    aresetn = 1'b0; din = '0; din_stable = 1'b0; evt.event_tready = 1'b0; overflow_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(evt.event_tvalid), 64'd0);
    check("rst_tdata",  64'(evt.event_tdata),  64'd0);
    check("rst_level",  64'(fifo_level),       64'd0);
    check("rst_ovf",    64'(overflow),         64'd0);
    aresetn = 1'b1;

    // Idle stable bus: arms silently, nothing queued
    for (int i = 0; i < 10; i++) begin
      step(4'h0, 1'b1, 1'b0, 1'b0);
      check("idle_tvalid", 64'(evt.event_tvalid), 64'd0);
    end
    check("idle_level", 64'(fifo_level), 64'd0);

    // Table-driven detection / pop / push+pop
    for (int i = 0; i < 11; i++) begin
      t = ts_m;
      step(vecs[i].din, vecs[i].st, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_tvalid", i), 64'(evt.event_tvalid), 64'(vecs[i].exp_v));
      check($sformatf("vec%0d_level", i),  64'(fifo_level),       64'(vecs[i].exp_lvl));
      check($sformatf("vec%0d_tdata", i),  64'(evt.event_tdata),
            vecs[i].exp_v ? 64'(mk(t, vecs[i].exp_fall, vecs[i].exp_rise)) : 64'd0);
      check($sformatf("vec%0d_ovf", i),    64'(overflow),         64'(vecs[i].exp_ovf));
    end

    // Glitch while unstable that settles back: no event
    step(4'h1, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b0);
    check("glitch_tvalid", 64'(evt.event_tvalid), 64'd0);
    check("glitch_level",  64'(fifo_level),       64'd0);
    // Change while unstable is reported only once stable returns
    step(4'h2, 1'b0, 1'b0, 1'b0);
    check("unstable_hold", 64'(evt.event_tvalid), 64'd0);
    t = ts_m;
    step(4'h2, 1'b1, 1'b0, 1'b0);
    check("late_event", 64'(evt.event_tdata), 64'(mk(t, 4'h0, 4'h2)));
    step(4'h2, 1'b1, 1'b1, 1'b0);
    check("late_pop_level", 64'(fifo_level), 64'd0);

    // Fill to full with tready low, fifth event dropped
    for (int i = 0; i < 5; i++) begin
      logic [3:0] d;
      d = (i % 2 == 0) ? 4'h3 : 4'h2;
      t = ts_m;
      step(d, 1'b1, 1'b0, 1'b0);
      if (i < 4) exp_q.push_back(mk(t, (d == 4'h2) ? 4'h1 : 4'h0, (d == 4'h3) ? 4'h1 : 4'h0));
    end
    check("full_level",  64'(fifo_level),       64'd4);
    check("full_ovf",    64'(overflow),         64'd1);
    check("full_tvalid", 64'(evt.event_tvalid), 64'd1);
    // Drop and clear on the same edge: drop wins
    step(4'h2, 1'b1, 1'b0, 1'b1);
    check("clr_vs_drop_ovf",   64'(overflow),   64'd1);
    check("clr_vs_drop_level", 64'(fifo_level), 64'd4);
    step(4'h2, 1'b1, 1'b0, 1'b0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    step(4'h2, 1'b1, 1'b0, 1'b1);
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Full FIFO: detection with a simultaneous pop is accepted
    t = ts_m;
    step(4'h3, 1'b1, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(t, 4'h0, 4'h1));
    check("pushpop_level", 64'(fifo_level), 64'd4);
    check("pushpop_ovf",   64'(overflow),   64'd0);

    // Drain and verify order and contents
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_tvalid", i), 64'(evt.event_tvalid), 64'd1);
      check($sformatf("drain%0d_tdata", i),  64'(evt.event_tdata),  64'(exp_q[i]));
      step(4'h3, 1'b1, 1'b1, 1'b0);
    end
    check("drained_level", 64'(fifo_level),       64'd0);
    check("drained_tdata", 64'(evt.event_tdata),  64'd0);
    // tready on empty FIFO is harmless
    step(4'h3, 1'b1, 1'b1, 1'b0);
    check("no_underflow", 64'(fifo_level), 64'd0);

    // Mid-operation reset with three entries queued
    step(4'h7, 1'b1, 1'b0, 1'b0);
    step(4'h3, 1'b1, 1'b0, 1'b0);
    step(4'h7, 1'b1, 1'b0, 1'b0);
    check("pre_rst_level", 64'(fifo_level), 64'd3);
    aresetn = 1'b0;
    step(4'h7, 1'b1, 1'b0, 1'b0);
    check("mid_rst_level",  64'(fifo_level),       64'd0);
    check("mid_rst_tvalid", 64'(evt.event_tvalid), 64'd0);
    check("mid_rst_tdata",  64'(evt.event_tdata),  64'd0);
    aresetn = 1'b1;
    step(4'h7, 1'b1, 1'b0, 1'b0);
    check("rearm_silent", 64'(evt.event_tvalid), 64'd0);
    step(4'h7, 1'b1, 1'b0, 1'b0);
    check("rearm_level", 64'(fifo_level), 64'd0);
    t = ts_m;
    step(4'h5, 1'b1, 1'b0, 1'b0);
    check("post_rst_event", 64'(evt.event_tdata), 64'(mk(t, 4'h2, 4'h0)));
    check("post_rst_ts",    64'(t),               64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
